// File: rtl/cdec_mem_pkg.sv
// cdec_mem_pkg: shared types and address-map helper for the CDEC memory subsystem.
// Provides the programmer FSM state enum, the I/O-window decode result struct and
// io_port_index(), which maps an address onto an I/O window slot (port k at top-k).
package cdec_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int IO_TOP     = (1 << ADDR_W_DEF) - 1;
  // The window can hold at most eight ports, so the slot index is 3 bits wide.
  localparam int IO_WIN     = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } prg_state_t;

  typedef struct packed {
    logic       hit;   // address falls inside the top IO_WIN slots
    logic [2:0] idx;   // slot k, counted down from the top address
  } io_sel_t;

  // The caller still has to compare idx against its own port count, because
  // window slots without a port fall through to RAM.
  function automatic io_sel_t io_port_index(input logic [31:0] addr, input int addr_w);
    logic [31:0] top;
    logic [31:0] k;
    io_sel_t     r;
    top   = (32'd1 << addr_w) - 32'd1;
    k     = top - addr;
    r.hit = (k < 32'(IO_WIN));
    r.idx = k[2:0];
    return r;
  endfunction

endpackage

// File: rtl/cdec_io_sync.sv
// cdec_io_sync: two-flop synchroniser for the input-port bus, used only when
// CDEC_MEM_IPORT_SYNC_EN is defined. Ports: clock, reset (async, active-high),
// d (asynchronous input bus), q (bus delayed by two rising edges, resets to 0).
module cdec_io_sync #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/cdec_mem_sys.sv
// cdec_mem_sys: CDEC word RAM plus a memory-mapped I/O window (port k at address 2**ADDR_W-1-k),
// shared by the CPU (cpu_we/cpu_MA/cpu_WD/cpu_RD, cpu_halt) and the monitor programmer
// (4-phase prg_req/prg_ack handshake with prg_we/prg_MA/prg_WD/prg_RD, prg_busy); iport in, oport out.
// Optional: define CDEC_MEM_IPORT_SYNC_EN to pass iport through a 2-flop synchroniser (reads lag 2 edges).
module cdec_mem_sys
  import cdec_mem_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int N_IPORT = 1,
  parameter int N_OPORT = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_MA,
  input  logic [DATA_W-1:0]           cpu_WD,
  output logic [DATA_W-1:0]           cpu_RD,
  input  logic                        cpu_halt,
  input  logic [N_IPORT*DATA_W-1:0]   iport,
  output logic [N_OPORT*DATA_W-1:0]   oport,
  input  logic                        prg_req,
  input  logic                        prg_we,
  input  logic [ADDR_W-1:0]           prg_MA,
  input  logic [DATA_W-1:0]           prg_WD,
  output logic [DATA_W-1:0]           prg_RD,
  output logic                        prg_ack,
  output logic                        prg_busy
);

  logic [N_IPORT*DATA_W-1:0] iport_eff;
  logic [DATA_W-1:0]         ram_q [2**ADDR_W];
  logic [DATA_W-1:0]         oport_q [N_OPORT];
  logic [DATA_W-1:0]         oport_d [N_OPORT];
  prg_state_t                state_q, state_d;
  logic [DATA_W-1:0]         prg_rd_q, prg_rd_d;

  logic              grant;
  logic              prg_wr;
  logic              wr_en;
  logic              wr_io;
  logic              ram_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_dat;
  io_sel_t           wr_sel;

`ifdef CDEC_MEM_IPORT_SYNC_EN
  cdec_io_sync #(.W(N_IPORT*DATA_W)) u_io_sync (
    .clock (clock),
    .reset (reset),
    .d     (iport),
    .q     (iport_eff)
  );
`else
  assign iport_eff = iport;
`endif

  // Shared read decode: input ports shadow the RAM only for slots that have a port.
  function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
    io_sel_t           s;
    logic [DATA_W-1:0] r;
    s = io_port_index(32'(a), ADDR_W);
    r = ram_q[a];
    for (int k = 0; k < N_IPORT; k++) begin
      if (s.hit && (s.idx == 3'(k))) r = iport_eff[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  // Single write port. The grant rule keeps the programmer away from an active
  // cpu_we; a halted CPU should not strobe MEMwe, but if it does while the
  // programmer is granted the programmer write takes the port so its ack is honest.
  always_comb begin
    grant   = cpu_halt | ~cpu_we;
    prg_wr  = (state_q == ACCESS) && grant && prg_we;
    wr_en   = cpu_we;
    wr_addr = cpu_MA;
    wr_dat  = cpu_WD;
    if (prg_wr) begin
      wr_en   = 1'b1;
      wr_addr = prg_MA;
      wr_dat  = prg_WD;
    end
    wr_sel  = io_port_index(32'(wr_addr), ADDR_W);
    wr_io   = 1'b0;
    oport_d = oport_q;
    for (int k = 0; k < N_OPORT; k++) begin
      if (wr_sel.hit && (wr_sel.idx == 3'(k))) begin
        wr_io = 1'b1;
        if (wr_en) oport_d[k] = wr_dat;
      end
    end
    ram_we = wr_en && !wr_io;
  end

  // Programmer handshake FSM.
  always_comb begin
    state_d  = state_q;
    prg_rd_d = prg_rd_q;
    case (state_q)
      IDLE: begin
        if (prg_req) state_d = ACCESS;
      end
      ACCESS: begin
        // Stalls for as long as the CPU keeps writing.
        if (grant) begin
          state_d = ACK;
          if (!prg_we) prg_rd_d = read_word(prg_MA);
        end
      end
      ACK: begin
        if (!prg_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      prg_rd_q <= '0;
      for (int k = 0; k < N_OPORT; k++) oport_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      prg_rd_q <= prg_rd_d;
      oport_q  <= oport_d;
    end
  end

  // RAM contents survive reset; an access aborted by reset never reaches ram_we
  // because state_q is forced out of ACCESS.
  always_ff @(posedge clock) begin
    if (ram_we) ram_q[wr_addr] <= wr_dat;
  end

  always_comb begin
    cpu_RD = read_word(cpu_MA);
  end

  for (genvar g = 0; g < N_OPORT; g++) begin : g_oport
    assign oport[g*DATA_W +: DATA_W] = oport_q[g];
  end

  assign prg_RD   = prg_rd_q;
  assign prg_ack  = (state_q == ACK);
  assign prg_busy = (state_q != IDLE);

endmodule

// File: tb/tb_cdec_mem_sys.sv
// tb_cdec_mem_sys: randomized self-checking bench for cdec_mem_sys (2 input, 3 output ports).
// Latency: n/a. Backpressure: CPU writes during a programmer request stall the handshake.
module tb_cdec_mem_sys;

  localparam int NI = 2;
  localparam int NO = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [7:0]  cpu_MA;
  logic [7:0]  cpu_WD;
  logic [7:0]  cpu_RD;
  logic        cpu_halt;
  logic [15:0] iport;
  logic [23:0] oport;
  logic        prg_req;
  logic        prg_we;
  logic [7:0]  prg_MA;
  logic [7:0]  prg_WD;
  logic [7:0]  prg_RD;
  logic        prg_ack;
  logic        prg_busy;

  cdec_mem_sys #(.DATA_W(8), .ADDR_W(8), .N_IPORT(NI), .N_OPORT(NO)) dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_we   (cpu_we),
    .cpu_MA   (cpu_MA),
    .cpu_WD   (cpu_WD),
    .cpu_RD   (cpu_RD),
    .cpu_halt (cpu_halt),
    .iport    (iport),
    .oport    (oport),
    .prg_req  (prg_req),
    .prg_we   (prg_we),
    .prg_MA   (prg_MA),
    .prg_WD   (prg_WD),
    .prg_RD   (prg_RD),
    .prg_ack  (prg_ack),
    .prg_busy (prg_busy)
  );

  always #5 clock = ~clock;

  // Reference model: memory map as plain arrays.
  logic [7:0] mem_m [256];
  bit         mem_v [256];
  logic [7:0] iport_m [NI];
  logic [7:0] oport_m [NO];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
    int k;
    k = 255 - int'(a);
    if (k < NO) oport_m[k] = d;
    else begin
      mem_m[a] = d;
      mem_v[a] = 1'b1;
    end
  endfunction

  // Returns {known, data}.
  function automatic logic [8:0] model_read(input logic [7:0] a);
    int k;
    k = 255 - int'(a);
    if (k < NI) return {1'b1, iport_m[k]};
    return {mem_v[a], mem_m[a]};
  endfunction

  function automatic logic [7:0] pick_addr();
    int r;
    r = $urandom_range(0, 23);
    if (r < 16) return 8'(r);
    return 8'(248 + r - 16);
  endfunction

  task automatic check_oport(input string tag);
    check_eq(tag, 32'(oport), 32'({oport_m[2], oport_m[1], oport_m[0]}));
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_MA = a;
    cpu_WD = d;
    cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    model_write(a, d);
    check_oport("cpu_wr_oport");
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] a);
    logic [8:0] r;
    cpu_MA = a;
    #2;
    r = model_read(a);
    if (r[8]) check_eq(tag, 32'(cpu_RD), 32'(r[7:0]));
  endtask

  task automatic set_iport(input logic [7:0] p1, input logic [7:0] p0);
    iport_m[1] = p1;
    iport_m[0] = p0;
    iport = {p1, p0};
    // Long enough for the optional synchroniser as well.
    repeat (3) tick();
  endtask

  // One programmer access. wem/hm give cpu_we/cpu_halt before each edge k (bit k);
  // ack is expected at the first edge k>=2 that is granted.
  task automatic prg_access(input bit we, input logic [7:0] a, input logic [7:0] d,
                            input logic [15:0] wem_in, input logic [15:0] hm_in, input int hold);
    logic [15:0] wem, hm;
    logic [7:0]  ca, cd;
    logic [8:0]  exp_rd;
    int          ackk;
    wem = wem_in & 16'h01FE;
    hm  = hm_in & 16'hFFFE;
    wem = wem & ~hm;
    ackk = 0;
    for (int k = 15; k >= 2; k--) if (!wem[k] || hm[k]) ackk = k;
    exp_rd = '0;
    prg_req = 1'b1;
    prg_we  = we;
    prg_MA  = a;
    prg_WD  = d;
    for (int k = 1; k <= ackk; k++) begin
      cpu_we   = wem[k];
      cpu_halt = hm[k];
      ca = pick_addr();
      cd = 8'($urandom);
      if (wem[k]) begin
        cpu_MA = ca;
        cpu_WD = cd;
      end
      tick();
      if (wem[k]) model_write(ca, cd);
      if (k == ackk) begin
        if (we) model_write(a, d);
        else exp_rd = model_read(a);
      end
      check_eq("prg_ack", 32'(prg_ack), 32'(k == ackk));
      check_eq("prg_busy", 32'(prg_busy), 32'd1);
      check_oport("prg_oport");
    end
    cpu_we   = 1'b0;
    cpu_halt = 1'b0;
    if (!we && exp_rd[8]) check_eq("prg_rd", 32'(prg_RD), 32'(exp_rd[7:0]));
    // Holding req: ack stays, and a CPU write to the target is not overwritten again.
    for (int h = 0; h < hold; h++) begin
      cd = 8'($urandom);
      cpu_MA = a;
      cpu_WD = cd;
      cpu_we = 1'b1;
      tick();
      cpu_we = 1'b0;
      model_write(a, cd);
      check_eq("hold_ack", 32'(prg_ack), 32'd1);
      if (!we && exp_rd[8]) check_eq("hold_rd", 32'(prg_RD), 32'(exp_rd[7:0]));
    end
    prg_req = 1'b0;
    tick();
    check_eq("drop_ack", 32'(prg_ack), 32'd0);
    check_eq("drop_busy", 32'(prg_busy), 32'd0);
    if (!we && exp_rd[8]) check_eq("idle_rd", 32'(prg_RD), 32'(exp_rd[7:0]));
    cpu_read("post_prg_rd", a);
  endtask

  initial begin
    logic [7:0] a;
    reset    = 1'b1;
    cpu_we   = 1'b0;
    cpu_MA   = '0;
    cpu_WD   = '0;
    cpu_halt = 1'b0;
    prg_req  = 1'b0;
    prg_we   = 1'b0;
    prg_MA   = '0;
    prg_WD   = '0;
    iport_m[0] = 8'hA1;
    iport_m[1] = 8'hB2;
    iport    = {iport_m[1], iport_m[0]};
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = '0;
      mem_v[i] = 1'b0;
    end
    for (int i = 0; i < NO; i++) oport_m[i] = '0;

    // Reset state.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_ack", 32'(prg_ack), 32'd0);
    check_eq("rst_busy", 32'(prg_busy), 32'd0);
    check_eq("rst_prg_rd", 32'(prg_RD), 32'd0);
    check_eq("rst_oport", 32'(oport), 32'd0);
    tick();
    reset = 1'b0;

    // Preload the addresses the random traffic uses.
    for (int i = 0; i < 24; i++) begin
      a = (i < 16) ? 8'(i) : 8'(248 + i - 16);
      cpu_write(a, 8'($urandom));
    end
    cpu_write(8'h30, 8'h11);

    // CPU RAM write/read and output port write.
    cpu_write(8'h10, 8'h5A);
    cpu_read("cpu_rd_10", 8'h10);
    cpu_write(8'hFF, 8'h3C);
    check_eq("oport0_3c", 32'(oport[7:0]), 32'h3C);
    cpu_write(8'hFD, 8'hC5);
    cpu_read("cpu_rd_fd_ram", 8'hFD);

    // Input ports.
    set_iport(8'hB2, 8'hA1);
    cpu_read("iport_ff", 8'hFF);
    cpu_read("iport_fe", 8'hFE);

    // Programmer write/read with the CPU halted: minimum latency.
    prg_access(1'b1, 8'h20, 8'h77, 16'h0000, 16'hFFFE, 0);
    prg_access(1'b0, 8'h20, 8'h00, 16'h0000, 16'hFFFE, 0);
    check_eq("prg_rd_77", 32'(prg_RD), 32'h77);

    // CPU writes stall the programmer for five edges.
    prg_access(1'b1, 8'h21, 8'h42, 16'h007C, 16'h0000, 0);
    // Request held three cycles past ack.
    prg_access(1'b1, 8'h22, 8'h44, 16'h0000, 16'h0000, 3);
    prg_access(1'b0, 8'h10, 8'h00, 16'h0000, 16'h0000, 0);

    // Reset in the middle of a stalled programmer write.
    prg_req = 1'b1;
    prg_we  = 1'b1;
    prg_MA  = 8'h30;
    prg_WD  = 8'h99;
    for (int k = 0; k < 2; k++) begin
      cpu_we = 1'b1;
      cpu_MA = 8'h05;
      cpu_WD = 8'($urandom);
      tick();
      model_write(8'h05, cpu_WD);
    end
    check_eq("pre_rst_busy", 32'(prg_busy), 32'd1);
    check_eq("pre_rst_ack", 32'(prg_ack), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ack", 32'(prg_ack), 32'd0);
    check_eq("mid_rst_busy", 32'(prg_busy), 32'd0);
    check_eq("mid_rst_prg_rd", 32'(prg_RD), 32'd0);
    check_eq("mid_rst_oport", 32'(oport), 32'd0);
    for (int i = 0; i < NO; i++) oport_m[i] = '0;
    cpu_we  = 1'b0;
    prg_req = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_eq("post_rst_busy", 32'(prg_busy), 32'd0);
    cpu_read("post_rst_ram30", 8'h30);

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 3))
        0: cpu_write(pick_addr(), 8'($urandom));
        1: cpu_read("rand_cpu_rd", pick_addr());
        2: prg_access(1'($urandom), pick_addr(), 8'($urandom),
                      16'($urandom),
                      16'($urandom & $urandom & $urandom),
                      $urandom_range(0, 3));
        default: set_iport(8'($urandom), 8'($urandom));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
